// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - opcode enumeration and operand-class helper shared by the ALU slice
package alu_exec_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ROB_W_DEF  = 4;
    localparam int OPT_W_DEF  = 7;

    // Shared opcode enumeration (decoder, RS, ROB and execute units agree on these codes)
    typedef enum logic [OPT_W_DEF-1:0] {
        OP_NOP = 7'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
    } opcode_e;

    // Second operand comes from rs2 for branches, R-type and the multiply group; otherwise imm
    function automatic logic uses_rs2(input logic [OPT_W_DEF-1:0] op);
        return (op >= OP_BEQ && op <= OP_BGEU) || (op >= OP_ADD && op <= OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - RS issue port plus ALU CDB / ROB resolution port
interface alu_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OPT_W  = 7
);
    logic              valid_from_rs;
    logic [OPT_W-1:0]  inst_type_from_rs;
    logic [ROB_W-1:0]  alias_from_rs;
    logic [DATA_W-1:0] Vi_from_rs;
    logic [DATA_W-1:0] Vj_from_rs;
    logic [DATA_W-1:0] imm_from_rs;
    logic [DATA_W-1:0] pc_from_rs;
    logic              valid_to_cdb;
    logic [ROB_W-1:0]  alias_to_cdb;
    logic [DATA_W-1:0] result_to_cdb;
    logic              jump_to_rob;
    logic [DATA_W-1:0] target_pc_to_rob;

    modport master (
        output valid_from_rs, inst_type_from_rs, alias_from_rs,
               Vi_from_rs, Vj_from_rs, imm_from_rs, pc_from_rs,
        input  valid_to_cdb, alias_to_cdb, result_to_cdb, jump_to_rob, target_pc_to_rob
    );

    modport slave (
        input  valid_from_rs, inst_type_from_rs, alias_from_rs,
               Vi_from_rs, Vj_from_rs, imm_from_rs, pc_from_rs,
        output valid_to_cdb, alias_to_cdb, result_to_cdb, jump_to_rob, target_pc_to_rob
    );
endinterface

// File: rtl/alu_branch_cmp.sv
// rtl/alu_branch_cmp.sv - equality, signed and unsigned less-than for branches and SLT*
module alu_branch_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              eq_o,
    output logic              lt_o,
    output logic              ltu_o
);
    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);
endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - two-stage ALU execute unit on the ALU CDB port; define ALU_MUL_EN for RV32M multiply
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OPT_W  = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           rollback_from_rob,
    alu_exec_unit_if.slave bus
);
    logic              s1_valid_q, s1_valid_d;
    logic [OPT_W-1:0]  s1_op_q;
    logic [ROB_W-1:0]  s1_alias_q;
    logic [DATA_W-1:0] s1_a_q, s1_b_q, s1_b_d, s1_imm_q, s1_pc_q;

    logic              cdb_valid_q, jump_q;
    logic [ROB_W-1:0]  cdb_alias_q;
    logic [DATA_W-1:0] result_q, target_q;

    logic [DATA_W-1:0] res_d, target_d, pc_plus4, pc_plus_imm, jalr_sum;
    logic              jump_d, cmp_eq, cmp_lt, cmp_ltu;

    localparam logic [DATA_W-1:0] FOUR    = {{(DATA_W-3){1'b0}}, 3'd4};
    localparam logic [DATA_W-1:0] BIT0_CLR = ~{{(DATA_W-1){1'b0}}, 1'b1};

`ifdef ALU_MUL_EN
    logic [DATA_W:0]            s1_ma_q, s1_mb_q, s1_ma_d, s1_mb_d;
    logic signed [2*DATA_W+1:0] mul_prod;
    logic                       unused_mul_hi;

    // Only MULHU/MULHSU treat an operand as unsigned; MUL's low word is sign-agnostic
    assign s1_ma_d = {(bus.inst_type_from_rs != OP_MULHU) & bus.Vi_from_rs[DATA_W-1], bus.Vi_from_rs};
    assign s1_mb_d = {((bus.inst_type_from_rs == OP_MUL) || (bus.inst_type_from_rs == OP_MULH))
                      & bus.Vj_from_rs[DATA_W-1], bus.Vj_from_rs};
    assign mul_prod      = $signed(s1_ma_q) * $signed(s1_mb_q);
    assign unused_mul_hi = ^mul_prod[2*DATA_W+1:2*DATA_W];
`endif

    assign s1_valid_d = bus.valid_from_rs & ~rollback_from_rob;
    assign s1_b_d     = uses_rs2(bus.inst_type_from_rs) ? bus.Vj_from_rs : bus.imm_from_rs;

    // Stage 1: capture the issued op and resolve which value feeds operand B
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_alias_q <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_imm_q   <= '0;
            s1_pc_q    <= '0;
`ifdef ALU_MUL_EN
            s1_ma_q    <= '0;
            s1_mb_q    <= '0;
`endif
        end else if (rdy) begin
            s1_valid_q <= s1_valid_d;
            if (s1_valid_d) begin
                s1_op_q    <= bus.inst_type_from_rs;
                s1_alias_q <= bus.alias_from_rs;
                s1_a_q     <= bus.Vi_from_rs;
                s1_b_q     <= s1_b_d;
                s1_imm_q   <= bus.imm_from_rs;
                s1_pc_q    <= bus.pc_from_rs;
`ifdef ALU_MUL_EN
                s1_ma_q    <= s1_ma_d;
                s1_mb_q    <= s1_mb_d;
`endif
            end
        end
    end

    alu_branch_cmp #(.DATA_W(DATA_W)) u_cmp (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .eq_o  (cmp_eq),
        .lt_o  (cmp_lt),
        .ltu_o (cmp_ltu)
    );

    assign pc_plus4    = s1_pc_q + FOUR;
    assign pc_plus_imm = s1_pc_q + s1_imm_q;
    assign jalr_sum    = s1_a_q + s1_imm_q;

    // Stage 2 datapath: result, taken flag and target for the op held in S1
    always_comb begin
        res_d    = '0;
        jump_d   = 1'b0;
        target_d = pc_plus4;
        case (s1_op_q)
            OP_LUI:             res_d = s1_imm_q;
            OP_AUIPC:           res_d = pc_plus_imm;
            OP_JAL:  begin res_d = pc_plus4; jump_d = 1'b1; target_d = pc_plus_imm; end
            OP_JALR: begin res_d = pc_plus4; jump_d = 1'b1; target_d = jalr_sum & BIT0_CLR; end
            OP_BEQ:             jump_d = cmp_eq;
            OP_BNE:             jump_d = ~cmp_eq;
            OP_BLT:             jump_d = cmp_lt;
            OP_BGE:             jump_d = ~cmp_lt;
            OP_BLTU:            jump_d = cmp_ltu;
            OP_BGEU:            jump_d = ~cmp_ltu;
            OP_ADD, OP_ADDI:    res_d = s1_a_q + s1_b_q;
            OP_SUB:             res_d = s1_a_q - s1_b_q;
            OP_AND, OP_ANDI:    res_d = s1_a_q & s1_b_q;
            OP_OR, OP_ORI:      res_d = s1_a_q | s1_b_q;
            OP_XOR, OP_XORI:    res_d = s1_a_q ^ s1_b_q;
            OP_SLL, OP_SLLI:    res_d = s1_a_q << s1_b_q[4:0];
            OP_SRL, OP_SRLI:    res_d = s1_a_q >> s1_b_q[4:0];
            OP_SRA, OP_SRAI:    res_d = $signed(s1_a_q) >>> s1_b_q[4:0];
            OP_SLT, OP_SLTI:    res_d = {{(DATA_W-1){1'b0}}, cmp_lt};
            OP_SLTU, OP_SLTIU:  res_d = {{(DATA_W-1){1'b0}}, cmp_ltu};
`ifdef ALU_MUL_EN
            OP_MUL:                        res_d = mul_prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_d = mul_prod[2*DATA_W-1:DATA_W];
`endif
            default:            res_d = '0;
        endcase
        // Branch targets only override pc+4 when the branch is taken
        if ((s1_op_q >= OP_BEQ) && (s1_op_q <= OP_BGEU) && jump_d)
            target_d = pc_plus_imm;
    end

    // Stage 2: register the CDB broadcast; data outputs hold while the pipe is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_alias_q <= '0;
            result_q    <= '0;
            jump_q      <= 1'b0;
            target_q    <= '0;
        end else if (rdy) begin
            if (rollback_from_rob || !s1_valid_q) begin
                cdb_valid_q <= 1'b0;
                cdb_alias_q <= '0;
            end else begin
                cdb_valid_q <= 1'b1;
                cdb_alias_q <= s1_alias_q;
                result_q    <= res_d;
                jump_q      <= jump_d;
                target_q    <= target_d;
            end
        end
    end

    assign bus.valid_to_cdb     = cdb_valid_q;
    assign bus.alias_to_cdb     = cdb_alias_q;
    assign bus.result_to_cdb    = result_q;
    assign bus.jump_to_rob      = jump_q;
    assign bus.target_pc_to_rob = target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed bench for alu_exec_unit against a behavioural model
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic rollback = 1'b0;
    int   checks = 0;
    int   passed = 0;

    alu_exec_unit_if #(.DATA_W(32), .ROB_W(4), .OPT_W(7)) bus ();

    alu_exec_unit #(.DATA_W(32), .ROB_W(4), .OPT_W(7)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .rollback_from_rob (rollback),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  al;
        logic [31:0] res;
        logic [31:0] tgt;
        logic        jmp;
    } ent_t;

    ent_t        pq[$];
    logic        m_valid, m_jmp;
    logic [3:0]  m_alias;
    logic [31:0] m_res, m_tgt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Architectural meaning of each opcode, straight from the ISA rules
    function automatic ent_t ref_exec(input logic [6:0] op, input logic [3:0] al,
                                      input logic [31:0] vi, input logic [31:0] vj,
                                      input logic [31:0] imm, input logic [31:0] pc);
        ent_t e;
        logic is_br;
        longint p;
        longint unsigned pu;
        e.al = al; e.res = 32'd0; e.jmp = 1'b0; e.tgt = pc + 32'd4;
        is_br = 1'b0;
        case (op)
            OP_LUI:   e.res = imm;
            OP_AUIPC: e.res = pc + imm;
            OP_JAL:   begin e.res = pc + 32'd4; e.jmp = 1'b1; e.tgt = pc + imm; end
            OP_JALR:  begin e.res = pc + 32'd4; e.jmp = 1'b1; e.tgt = (vi + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   begin is_br = 1'b1; e.jmp = (vi == vj); end
            OP_BNE:   begin is_br = 1'b1; e.jmp = (vi != vj); end
            OP_BLT:   begin is_br = 1'b1; e.jmp = ($signed(vi) < $signed(vj)); end
            OP_BGE:   begin is_br = 1'b1; e.jmp = ($signed(vi) >= $signed(vj)); end
            OP_BLTU:  begin is_br = 1'b1; e.jmp = (vi < vj); end
            OP_BGEU:  begin is_br = 1'b1; e.jmp = (vi >= vj); end
            OP_ADDI:  e.res = vi + imm;
            OP_SLTI:  e.res = ($signed(vi) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: e.res = (vi < imm) ? 32'd1 : 32'd0;
            OP_XORI:  e.res = vi ^ imm;
            OP_ORI:   e.res = vi | imm;
            OP_ANDI:  e.res = vi & imm;
            OP_SLLI:  e.res = vi << imm[4:0];
            OP_SRLI:  e.res = vi >> imm[4:0];
            OP_SRAI:  e.res = $signed(vi) >>> imm[4:0];
            OP_ADD:   e.res = vi + vj;
            OP_SUB:   e.res = vi - vj;
            OP_SLL:   e.res = vi << vj[4:0];
            OP_SLT:   e.res = ($signed(vi) < $signed(vj)) ? 32'd1 : 32'd0;
            OP_SLTU:  e.res = (vi < vj) ? 32'd1 : 32'd0;
            OP_XOR:   e.res = vi ^ vj;
            OP_SRL:   e.res = vi >> vj[4:0];
            OP_SRA:   e.res = $signed(vi) >>> vj[4:0];
            OP_OR:    e.res = vi | vj;
            OP_AND:   e.res = vi & vj;
`ifdef ALU_MUL_EN
            OP_MUL:    begin p = longint'($signed(vi)) * longint'($signed(vj)); e.res = p[31:0]; end
            OP_MULH:   begin p = longint'($signed(vi)) * longint'($signed(vj)); e.res = p[63:32]; end
            OP_MULHSU: begin p = longint'($signed(vi)) * longint'({32'd0, vj}); e.res = p[63:32]; end
            OP_MULHU:  begin pu = {32'd0, vi} * {32'd0, vj}; e.res = pu[63:32]; end
`endif
            default: ;
        endcase
        if (is_br && e.jmp) e.tgt = pc + imm;
        return e;
    endfunction

    // Model: each captured op emerges on the CDB at the next active edge; rollback discards everything
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq.delete();
            m_valid <= 1'b0; m_alias <= 4'd0; m_res <= 32'd0; m_jmp <= 1'b0; m_tgt <= 32'd0;
        end else if (rdy) begin
            if (rollback) begin
                pq.delete();
                m_valid <= 1'b0; m_alias <= 4'd0;
            end else begin
                if (pq.size() != 0) begin
                    m_valid <= 1'b1; m_alias <= pq[0].al;
                    m_res <= pq[0].res; m_jmp <= pq[0].jmp; m_tgt <= pq[0].tgt;
                    pq.pop_front();
                end else begin
                    m_valid <= 1'b0; m_alias <= 4'd0;
                end
                if (bus.valid_from_rs)
                    pq.push_back(ref_exec(bus.inst_type_from_rs, bus.alias_from_rs, bus.Vi_from_rs,
                                          bus.Vj_from_rs, bus.imm_from_rs, bus.pc_from_rs));
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("cmp_valid",  bus.valid_to_cdb,     m_valid);
        chk("cmp_alias",  bus.alias_to_cdb,     m_alias);
        chk("cmp_result", bus.result_to_cdb,    m_res);
        chk("cmp_jump",   bus.jump_to_rob,      m_jmp);
        chk("cmp_target", bus.target_pc_to_rob, m_tgt);
    end

    task automatic issue1(input logic [6:0] op, input logic [3:0] al, input logic [31:0] vi,
                          input logic [31:0] vj, input logic [31:0] imm, input logic [31:0] pc);
        bus.valid_from_rs = 1'b1; bus.inst_type_from_rs = op; bus.alias_from_rs = al;
        bus.Vi_from_rs = vi; bus.Vj_from_rs = vj; bus.imm_from_rs = imm; bus.pc_from_rs = pc;
        @(negedge clk);
        bus.valid_from_rs = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [3:0] al,
                              input logic [31:0] res, input logic j, input logic [31:0] tgt);
        chk({nm, "_valid"},  bus.valid_to_cdb,     v);
        chk({nm, "_alias"},  bus.alias_to_cdb,     al);
        chk({nm, "_result"}, bus.result_to_cdb,    res);
        chk({nm, "_jump"},   bus.jump_to_rob,      j);
        chk({nm, "_target"}, bus.target_pc_to_rob, tgt);
    endtask

    logic [15:0] seen;
    task automatic step_rec();
        @(negedge clk);
        if (bus.valid_to_cdb) seen[bus.alias_to_cdb] = 1'b1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] exp_mulh;

    initial begin
`ifdef ALU_MUL_EN
        exp_mulh = 32'h4000_0000;
`else
        exp_mulh = 32'd0;
`endif
        bus.valid_from_rs = 1'b0; bus.inst_type_from_rs = '0; bus.alias_from_rs = '0;
        bus.Vi_from_rs = '0; bus.Vj_from_rs = '0; bus.imm_from_rs = '0; bus.pc_from_rs = '0;

        repeat (3) @(negedge clk);
        expect_out("reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ADDI overflow wrap, exact 2-cycle latency, single-cycle strobe
        issue1(OP_ADDI, 4'd3, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'h1000);
        chk("addi_lat1_valid", bus.valid_to_cdb, 1'b0);
        @(negedge clk);
        expect_out("addi", 1'b1, 4'd3, 32'h8000_0000, 1'b0, 32'h1004);
        @(negedge clk);
        chk("addi_drop_valid", bus.valid_to_cdb, 1'b0);

        // Signed vs unsigned branch on the same operands, back to back
        issue1(OP_BLT,  4'd5, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        issue1(OP_BLTU, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        expect_out("blt", 1'b1, 4'd5, 32'd0, 1'b1, 32'h120);
        @(negedge clk);
        expect_out("bltu", 1'b1, 4'd6, 32'd0, 1'b0, 32'h104);

        issue1(OP_JALR, 4'd7, 32'h203, 32'd0, 32'h10, 32'h40);
        @(negedge clk);
        expect_out("jalr", 1'b1, 4'd7, 32'h44, 1'b1, 32'h212);

        issue1(OP_MULH, 4'd8, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h80);
        @(negedge clk);
        expect_out("mulh", 1'b1, 4'd8, exp_mulh, 1'b0, 32'h84);

        // Stall with S1 loaded: outputs frozen, broadcast one cycle after rdy returns
        issue1(OP_SUB, 4'd9, 32'd5, 32'd7, 32'd0, 32'h200);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", bus.valid_to_cdb, 1'b0);
            chk("stall_result", bus.result_to_cdb, exp_mulh);
        end
        rdy = 1'b1;
        @(negedge clk);
        expect_out("after_stall", 1'b1, 4'd9, 32'hFFFF_FFFE, 1'b0, 32'h204);
        @(negedge clk);

        // Rollback coincident with the third issue
        seen = '0;
        bus.valid_from_rs = 1'b1; bus.inst_type_from_rs = OP_ADD; bus.Vi_from_rs = 32'd10;
        bus.Vj_from_rs = 32'd20; bus.pc_from_rs = 32'h300;
        bus.alias_from_rs = 4'd1; step_rec();
        bus.alias_from_rs = 4'd2; step_rec();
        bus.alias_from_rs = 4'd3; rollback = 1'b1; step_rec();
        rollback = 1'b0;
        bus.alias_from_rs = 4'd4; step_rec();
        bus.valid_from_rs = 1'b0;
        repeat (4) step_rec();
        chk("rb_alias1_seen", seen[1], 1'b1);
        chk("rb_alias2_seen", seen[2], 1'b0);
        chk("rb_alias3_seen", seen[3], 1'b0);
        chk("rb_alias4_seen", seen[4], 1'b1);

        // Asynchronous reset with both stages full
        bus.valid_from_rs = 1'b1; bus.inst_type_from_rs = OP_ADD; bus.alias_from_rs = 4'd10;
        @(negedge clk);
        bus.alias_from_rs = 4'd11;
        @(negedge clk);
        chk("pre_reset_valid", bus.valid_to_cdb, 1'b1);
        chk("pre_reset_alias", bus.alias_to_cdb, 4'd10);
        #2 rst = 1'b0;
        bus.valid_from_rs = 1'b0;
        #1 expect_out("async_reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_valid", bus.valid_to_cdb, 1'b0);
        end

        // Randomized traffic with stalls, rollbacks and unknown opcodes
        for (int i = 0; i < 400; i++) begin
            rdy = (($urandom % 10) != 0);
            rollback = (($urandom % 20) == 0);
            bus.valid_from_rs = (($urandom % 10) < 7);
            bus.inst_type_from_rs = (($urandom % 8) == 0) ? 7'($urandom_range(0, 127))
                                                          : 7'($urandom_range(0, 45));
            bus.alias_from_rs = 4'($urandom_range(1, 15));
            bus.Vi_from_rs = rnd_word();
            bus.Vj_from_rs = rnd_word();
            bus.imm_from_rs = rnd_word();
            bus.pc_from_rs = {$urandom, 2'b00} ;
            @(negedge clk);
        end
        bus.valid_from_rs = 1'b0;
        rollback = 1'b0;
        rdy = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Consumer end of the reservation-station issue interface. Accepts at most one ready instruction per cycle (opcode, ROB alias, operands, imm, pc) and executes it.
- Broadcasts the result on the ALU CDB port consumed by RS, LSB and ROB. Reports branch/jump resolution to the ROB.
- Fixed two-stage pipeline, no backpressure: the RS issues without a ready signal, so the unit sustains 1 op/cycle.

Parameters:
- DATA_W, 32, operand/result width
- ROB_W, 4, ROB alias width; alias 0 is reserved as "no tag"
- OPT_W, 7, inst_type width, matching the shared opcode enumeration

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- rollback_from_rob  in  1  flush all in-flight work
- valid_from_rs  in  1  issue strobe
- inst_type_from_rs  in  OPT_W  opcode from shared enumeration
- alias_from_rs  in  ROB_W  destination ROB tag
- Vi_from_rs  in  DATA_W  rs1 value
- Vj_from_rs  in  DATA_W  rs2 value
- imm_from_rs  in  DATA_W  sign-extended immediate
- pc_from_rs  in  DATA_W  instruction pc
- valid_to_cdb  out  1  result broadcast strobe
- alias_to_cdb  out  ROB_W  tag of broadcast result
- result_to_cdb  out  DATA_W  rd value
- jump_to_rob  out  1  control transfer taken (branch taken, JAL, JALR)
- target_pc_to_rob  out  DATA_W  resolved target when jump_to_rob=1, else pc+4

Behaviour:
- Reset: asynchronous on rst low. All outputs are 0, both stage-valid bits are 0, and all pipeline registers are 0.
- rdy low: every register holds and no new issue is captured. The RS also freezes under the same rdy, so no issue is lost.
- Stage 1 (S1): when valid_from_rs is high, the unit captures all issue fields and precomputes opB, which is Vj for R-type/branch and imm otherwise. s1_valid is set from valid_from_rs each cycle.
- Stage 2 (S2): computes from S1 and registers the CDB outputs. Latency from issue to valid_to_cdb is exactly 2 cycles.
- valid_to_cdb is high for exactly one cycle per issued op. When S1 is empty, the unit drives valid_to_cdb=0 and alias_to_cdb=0; jump_to_rob and the data outputs hold their last values.
- Results:
  - ADD/ADDI: wrap mod 2^32. SUB: wrap.
  - AND/OR/XOR (+I): bitwise.
  - SLL/SRL/SRA (+I): shift amount is opB[4:0]. SRA is arithmetic.
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Both produce 0/1.
  - LUI: imm. AUIPC: pc+imm.
  - JAL: result pc+4, target pc+imm. JALR: result pc+4, target (Vi+imm) with bit0 cleared.
  - BEQ/BNE/BLT/BGE (signed), BLTU/BGEU (unsigned): result 0. Taken gives target pc+imm; not-taken gives target pc+4.
- Unknown opcode: result 0, jump 0, target pc+4. It is still broadcast so the ROB entry retires.
- Rollback: synchronously clears s1_valid and valid_to_cdb in the same edge. An issue strobe coincident with rollback is dropped. Rollback has priority over rdy=1 activity but not over reset.
- Back-to-back dependent ops are allowed. The RS forwards the CDB value combinationally at dispatch and capture, so the unit has no internal forwarding.
- No internal buffering beyond the two stages. Full throughput is guaranteed and there is no overflow condition.

Optional Feature:
- ALU_MUL_EN defined: adds RV32M MUL, MULH, MULHSU, MULHU.
  - S1 forms sign-extended 33-bit operands.
  - S2 computes the 66-bit product and selects the low word (MUL) or the high word (others).
  - Latency stays 2 cycles.
- ALU_MUL_EN undefined: these opcodes are handled as unknown, giving result 0 and a normal broadcast. No multiplier logic is synthesized.

Decomposition:
- Shared package (utils.v): DATA_RANGE, ROB_RANGE and OPT_RANGE macros, plus the opcode enumeration constants (LUI through AND, MUL group) shared with the decoder, RS and ROB.
- One natural sub-module, alu_branch_cmp: combinational eq/lt/ltu comparator used in S2 for branches and SLT*.

Test Plan:
- Reset values: assert rst=0 mid-stream with S1 and S2 valid -> all outputs 0 immediately. After rst=1, no broadcast until a new issue.
- ADDI: Vi=0x7FFFFFFF, imm=1, alias=3 -> 2 cycles later valid_to_cdb=1, alias=3, result=0x80000000, jump=0, then valid drops next cycle.
- Branch: BLT with Vi=0xFFFFFFFF (−1), Vj=1, pc=0x100, imm=0x20 -> jump=1, target=0x120. BLTU with same operands -> jump=0, target=0x104.
- JALR: Vi=0x203, imm=0x10, pc=0x40 -> result=0x44, target=0x212, jump=1.
- Throughput and rollback: issue 4 consecutive ops (aliases 1,2,3,4) and assert rollback on the cycle alias 3 is issued -> CDB shows alias 1 only. Aliases 2 and 3 are never broadcast; alias 4, issued the next cycle, broadcasts normally.
- Stall and MUL: hold rdy=0 for 3 cycles with S1 loaded -> the output is unchanged and then appears 1 cycle after rdy returns. With ALU_MUL_EN, MULH 0x80000000×0x80000000 -> 0x40000000. Without ALU_MUL_EN -> 0.
